// File: rtl/snake_if.sv
// Bundles the snake engine's game controls, pixel query and status outputs.
// The master side (game logic / bench) drives controls; the engine is the slave.
interface snake_if #(
  parameter int LEN_W = 8,
  parameter int HX_W  = 7,
  parameter int HY_W  = 6
);
  logic             mv_tick;
  logic             BTNU;
  logic             BTND;
  logic             BTNL;
  logic             BTNR;
  logic             SWPAUSE;
  logic             got_apple;
  logic [9:0]       pixel_row;
  logic [9:0]       pixel_column;
  logic             head_on;
  logic             body_on;
  logic             collided;
  logic [LEN_W-1:0] length;
  logic [HX_W-1:0]  head_x;
  logic [HY_W-1:0]  head_y;
  logic             busy;
  logic             overrun;

  modport master (
    output mv_tick, BTNU, BTND, BTNL, BTNR, SWPAUSE, got_apple, pixel_row, pixel_column,
    input  head_on, body_on, collided, length, head_x, head_y, busy, overrun
  );

  modport slave (
    input  mv_tick, BTNU, BTND, BTNL, BTNR, SWPAUSE, got_apple, pixel_row, pixel_column,
    output head_on, body_on, collided, length, head_x, head_y, busy, overrun
  );
endinterface

// File: rtl/snake_engine.sv
// Snake body held in a circular slot buffer; each move is checked by a scan FSM before commit.
// Define SNAKE_WRAP_EN to remove the walls and wrap the head around the grid edges.
module snake_engine #(
  parameter int MAX_LEN        = 128,
  parameter int START_LEN      = 4,
  parameter int X_CELLS        = 80,
  parameter int Y_CELLS        = 60,
  parameter int CELL_SHIFT     = 3,
  parameter int START_X        = 5,
  parameter int START_Y        = 30,
  parameter int GROW_PER_APPLE = 1
) (
  input logic     VGA_clk,
  input logic     SWRES,
  snake_if.slave  bus
);
  localparam int PW = $clog2(MAX_LEN);
  localparam int LW = PW + 1;
  localparam int XW = $clog2(X_CELLS);
  localparam int YW = $clog2(Y_CELLS);

  typedef enum logic [2:0] {IDLE, CALC, SCAN, COMMIT, DEAD} state_t;
  // Encoding chosen so that the opposite direction is d ^ 1.
  typedef enum logic [1:0] {UP = 2'd0, DOWN = 2'd1, LEFT = 2'd2, RIGHT = 2'd3} dir_t;

  state_t        state, state_n;
  dir_t          cur_dir, pend_dir, req_dir;
  logic          req_valid, go, grow, grow_r, wall, hit, collided, overrun;
  logic [XW-1:0] seg_x [MAX_LEN];
  logic [YW-1:0] seg_y [MAX_LEN];
  logic [PW-1:0] head_ptr, scan_slot, rend_i;
  logic [LW-1:0] length, grow_cnt, grow_n, idx, scan_limit;
  logic [LW:0]   grow_sum;
  logic [XW-1:0] hx, nx;
  logic [YW-1:0] hy, ny;
  logic [XW:0]   calc_nx;
  logic [YW:0]   calc_ny;
  logic [9:0]    px, py;

  assign hx         = seg_x[head_ptr];
  assign hy         = seg_y[head_ptr];
  assign go         = bus.mv_tick && !bus.SWPAUSE && !collided;
  assign grow       = (grow_cnt != '0) && (length < LW'(MAX_LEN));
  assign scan_limit = grow_r ? length : length - LW'(1);
  assign scan_slot  = head_ptr - idx[PW-1:0];
  assign hit        = (idx < scan_limit) && (seg_x[scan_slot] == nx) && (seg_y[scan_slot] == ny);

  always_comb begin
    req_valid = 1'b1;
    req_dir   = RIGHT;
    if (bus.BTNU)      req_dir = UP;
    else if (bus.BTNL) req_dir = LEFT;
    else if (bus.BTND) req_dir = DOWN;
    else if (bus.BTNR) req_dir = RIGHT;
    else               req_valid = 1'b0;
  end

  always_comb begin
    calc_nx = {1'b0, hx};
    calc_ny = {1'b0, hy};
`ifdef SNAKE_WRAP_EN
    case (cur_dir)
      LEFT:  calc_nx = (hx == '0) ? (XW+1)'(X_CELLS - 1) : {1'b0, hx} - (XW+1)'(1);
      RIGHT: calc_nx = (hx == XW'(X_CELLS - 1)) ? '0 : {1'b0, hx} + (XW+1)'(1);
      UP:    calc_ny = (hy == '0) ? (YW+1)'(Y_CELLS - 1) : {1'b0, hy} - (YW+1)'(1);
      default: calc_ny = (hy == YW'(Y_CELLS - 1)) ? '0 : {1'b0, hy} + (YW+1)'(1);
    endcase
    wall = 1'b0;
`else
    case (cur_dir)
      LEFT:    calc_nx = {1'b0, hx} - (XW+1)'(1);
      RIGHT:   calc_nx = {1'b0, hx} + (XW+1)'(1);
      UP:      calc_ny = {1'b0, hy} - (YW+1)'(1);
      default: calc_ny = {1'b0, hy} + (YW+1)'(1);
    endcase
    wall = (calc_nx == '0) || (calc_nx == (XW+1)'(X_CELLS - 1)) ||
           (calc_ny == '0) || (calc_ny == (YW+1)'(Y_CELLS - 1));
`endif
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (go) state_n = CALC;
      CALC:    state_n = wall ? DEAD : SCAN;
      SCAN: begin
        if (hit)                             state_n = DEAD;
        else if (idx + LW'(1) >= scan_limit) state_n = COMMIT;
      end
      COMMIT:  state_n = IDLE;
      DEAD:    state_n = DEAD;
      default: state_n = IDLE;
    endcase
  end

  // Apple requests and the commit-time decrement may land together; apply the net change.
  always_comb begin
    grow_sum = {1'b0, grow_cnt};
    if (bus.got_apple && state != DEAD) grow_sum = grow_sum + (LW+1)'(GROW_PER_APPLE);
    if (state == COMMIT && grow_r)      grow_sum = grow_sum - (LW+1)'(1);
    if (grow_sum > (LW+1)'(MAX_LEN))    grow_sum = (LW+1)'(MAX_LEN);
    grow_n = grow_sum[LW-1:0];
  end

  always_ff @(posedge VGA_clk or posedge SWRES) begin
    if (SWRES) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge VGA_clk or posedge SWRES) begin
    if (SWRES) begin
      head_ptr <= '0;
      length   <= LW'(START_LEN);
      grow_cnt <= '0;
      cur_dir  <= RIGHT;
      pend_dir <= RIGHT;
      grow_r   <= 1'b0;
      idx      <= '0;
      nx       <= '0;
      ny       <= '0;
      collided <= 1'b0;
      overrun  <= 1'b0;
      for (int j = 0; j < MAX_LEN; j++) begin
        seg_x[j] <= (((MAX_LEN - j) % MAX_LEN) < START_LEN) ?
                    XW'(START_X - ((MAX_LEN - j) % MAX_LEN)) : '0;
        seg_y[j] <= (((MAX_LEN - j) % MAX_LEN) < START_LEN) ? YW'(START_Y) : '0;
      end
    end else begin
      grow_cnt <= grow_n;
      if (req_valid && (req_dir != dir_t'(cur_dir ^ 2'd1))) pend_dir <= req_dir;
      if (bus.mv_tick && state != IDLE) overrun <= 1'b1;
      if (state_n == DEAD) collided <= 1'b1;
      case (state)
        IDLE: if (go) cur_dir <= pend_dir;
        CALC: begin
          nx     <= calc_nx[XW-1:0];
          ny     <= calc_ny[YW-1:0];
          grow_r <= grow;
          idx    <= '0;
        end
        SCAN: idx <= idx + LW'(1);
        COMMIT: begin
          head_ptr                  <= head_ptr + PW'(1);
          seg_x[head_ptr + PW'(1)]  <= nx;
          seg_y[head_ptr + PW'(1)]  <= ny;
          if (grow_r) length <= length + LW'(1);
        end
        default: ;
      endcase
    end
  end

  assign px = bus.pixel_column >> CELL_SHIFT;
  assign py = bus.pixel_row >> CELL_SHIFT;

  // Walk every slot and recover its segment index to decide whether it is active body.
  always_comb begin
    bus.head_on = (px == 10'(hx)) && (py == 10'(hy));
    bus.body_on = 1'b0;
    rend_i      = '0;
    for (int j = 0; j < MAX_LEN; j++) begin
      rend_i = head_ptr - PW'(j);
      if ((rend_i != '0) && ({1'b0, rend_i} < length) &&
          (px == 10'(seg_x[j])) && (py == 10'(seg_y[j])))
        bus.body_on = 1'b1;
    end
  end

  assign bus.collided = collided;
  assign bus.length   = length;
  assign bus.head_x   = hx;
  assign bus.head_y   = hy;
  assign bus.busy     = (state != IDLE);
  assign bus.overrun  = overrun;
endmodule

// File: tb/tb_snake_engine.sv
// Directed bench for snake_engine: movement, steering, growth, walls, self collision, overrun, reset.
// Expectations follow the wrap behaviour when SNAKE_WRAP_EN is defined.
module tb_snake_engine;
  logic VGA_clk = 1'b0;
  logic SWRES   = 1'b1;
  int   total   = 0;
  int   bad     = 0;
  int   cyc;

  snake_if bus ();

  snake_engine dut (
    .VGA_clk (VGA_clk),
    .SWRES   (SWRES),
    .bus     (bus)
  );

  always #5 VGA_clk = ~VGA_clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // One move: a single-cycle mv_tick, then wait (bounded) for the FSM to settle or die.
  task automatic applyStimulus(output int cycles);
    cycles = 1;
    bus.mv_tick = 1'b1;
    @(posedge VGA_clk); #1;
    bus.mv_tick = 1'b0;
    while ((bus.busy === 1'b1) && (bus.collided !== 1'b1) && (cycles < 300)) begin
      @(posedge VGA_clk); #1;
      cycles++;
    end
    checkOutput("move_bounded", 32'(cycles < 300), 1);
  endtask

  task automatic pressBtn(input logic [3:0] uldr);
    {bus.BTNU, bus.BTNL, bus.BTND, bus.BTNR} = uldr;
    @(posedge VGA_clk); #1;
    {bus.BTNU, bus.BTNL, bus.BTND, bus.BTNR} = 4'b0000;
  endtask

  task automatic probe(input int cx, input int cy);
    bus.pixel_column = 10'(cx * 8 + 3);
    bus.pixel_row    = 10'(cy * 8 + 5);
    #1;
  endtask

  task automatic doReset();
    SWRES = 1'b1;
    @(posedge VGA_clk); #1;
    SWRES = 1'b0;
    @(posedge VGA_clk); #1;
  endtask

  initial begin
    bus.mv_tick = 1'b0; bus.SWPAUSE = 1'b0; bus.got_apple = 1'b0;
    {bus.BTNU, bus.BTNL, bus.BTND, bus.BTNR} = 4'b0000;
    bus.pixel_column = '0; bus.pixel_row = '0;
    doReset();

    checkOutput("rst_length", 32'(bus.length), 4);
    checkOutput("rst_head_x", 32'(bus.head_x), 5);
    checkOutput("rst_head_y", 32'(bus.head_y), 30);
    checkOutput("rst_busy", 32'(bus.busy), 0);
    checkOutput("rst_collided", 32'(bus.collided), 0);
    probe(5, 30); checkOutput("rst_head_on", 32'(bus.head_on), 1);
    checkOutput("rst_head_not_body", 32'(bus.body_on), 0);
    probe(2, 30); checkOutput("rst_tail_body", 32'(bus.body_on), 1);
    probe(1, 30); checkOutput("rst_beyond_tail", 32'(bus.body_on), 0);

    applyStimulus(cyc);
    checkOutput("mv1_latency_ok", 32'(cyc <= 7), 1);
    checkOutput("mv1_head_x", 32'(bus.head_x), 6);
    checkOutput("mv1_head_y", 32'(bus.head_y), 30);
    checkOutput("mv1_length", 32'(bus.length), 4);
    probe(5, 30); checkOutput("mv1_body5", 32'(bus.body_on), 1);
    probe(3, 30); checkOutput("mv1_body3", 32'(bus.body_on), 1);
    probe(2, 30); checkOutput("mv1_old_tail", 32'(bus.body_on), 0);

    pressBtn(4'b0100);
    applyStimulus(cyc);
    checkOutput("norev_head_x", 32'(bus.head_x), 7);
    checkOutput("norev_head_y", 32'(bus.head_y), 30);
    pressBtn(4'b1000);
    applyStimulus(cyc);
    checkOutput("up_head_x", 32'(bus.head_x), 7);
    checkOutput("up_head_y", 32'(bus.head_y), 29);

    bus.got_apple = 1'b1;
    @(posedge VGA_clk); #1;
    bus.got_apple = 1'b0;
    applyStimulus(cyc);
    checkOutput("grow_len5", 32'(bus.length), 5);
    checkOutput("grow_head_y", 32'(bus.head_y), 28);
    probe(5, 30); checkOutput("grow_tail_kept", 32'(bus.body_on), 1);
    applyStimulus(cyc);
    checkOutput("grow_len_hold", 32'(bus.length), 5);
    probe(5, 30); checkOutput("grow_tail_released", 32'(bus.body_on), 0);
    probe(6, 30); checkOutput("grow_new_tail", 32'(bus.body_on), 1);

    // Length 4: U, L, D lands on the tail, which vacates in the same move.
    doReset();
    applyStimulus(cyc);
    pressBtn(4'b1000); applyStimulus(cyc);
    pressBtn(4'b0100); applyStimulus(cyc);
    pressBtn(4'b0010); applyStimulus(cyc);
    checkOutput("loop4_collided", 32'(bus.collided), 0);
    checkOutput("loop4_head_x", 32'(bus.head_x), 5);
    checkOutput("loop4_head_y", 32'(bus.head_y), 30);

    // Length 5: the same loop now hits a live body segment.
    doReset();
    bus.got_apple = 1'b1;
    @(posedge VGA_clk); #1;
    bus.got_apple = 1'b0;
    applyStimulus(cyc);
    checkOutput("loop5_length", 32'(bus.length), 5);
    pressBtn(4'b1000); applyStimulus(cyc);
    pressBtn(4'b0100); applyStimulus(cyc);
    pressBtn(4'b0010); applyStimulus(cyc);
    checkOutput("loop5_collided", 32'(bus.collided), 1);
    checkOutput("loop5_head_x", 32'(bus.head_x), 5);
    checkOutput("loop5_head_y", 32'(bus.head_y), 29);
    checkOutput("loop5_busy", 32'(bus.busy), 1);

    doReset();
    for (int k = 0; k < 73; k++) applyStimulus(cyc);
    checkOutput("wall_pre_x", 32'(bus.head_x), 78);
    checkOutput("wall_pre_collided", 32'(bus.collided), 0);
    applyStimulus(cyc);
`ifdef SNAKE_WRAP_EN
    checkOutput("wrap_x79", 32'(bus.head_x), 79);
    checkOutput("wrap_collided79", 32'(bus.collided), 0);
    applyStimulus(cyc);
    checkOutput("wrap_x0", 32'(bus.head_x), 0);
    checkOutput("wrap_collided0", 32'(bus.collided), 0);
`else
    checkOutput("wall_collided", 32'(bus.collided), 1);
    checkOutput("wall_frozen_x", 32'(bus.head_x), 78);
    checkOutput("wall_length", 32'(bus.length), 4);
`endif

    doReset();
    bus.SWPAUSE = 1'b1;
    bus.mv_tick = 1'b1;
    @(posedge VGA_clk); #1;
    bus.mv_tick = 1'b0;
    repeat (8) @(posedge VGA_clk);
    #1;
    bus.SWPAUSE = 1'b0;
    checkOutput("pause_head_x", 32'(bus.head_x), 5);
    checkOutput("pause_overrun", 32'(bus.overrun), 0);

    bus.mv_tick = 1'b1;
    @(posedge VGA_clk); #1;
    bus.mv_tick = 1'b0;
    @(posedge VGA_clk); #1;
    bus.mv_tick = 1'b1;
    @(posedge VGA_clk); #1;
    bus.mv_tick = 1'b0;
    cyc = 0;
    while ((bus.busy === 1'b1) && (cyc < 300)) begin
      @(posedge VGA_clk); #1;
      cyc++;
    end
    checkOutput("ovr_settled", 32'(cyc < 300), 1);
    checkOutput("ovr_flag", 32'(bus.overrun), 1);
    checkOutput("ovr_one_move", 32'(bus.head_x), 6);

    bus.mv_tick = 1'b1;
    @(posedge VGA_clk); #1;
    bus.mv_tick = 1'b0;
    @(posedge VGA_clk); #1;
    checkOutput("midscan_busy", 32'(bus.busy), 1);
    SWRES = 1'b1;
    #1;
    checkOutput("midscan_rst_busy", 32'(bus.busy), 0);
    checkOutput("midscan_rst_x", 32'(bus.head_x), 5);
    checkOutput("midscan_rst_overrun", 32'(bus.overrun), 0);
    @(posedge VGA_clk); #1;
    SWRES = 1'b0;
    @(posedge VGA_clk); #1;
    probe(6, 30); checkOutput("midscan_no_write", 32'(bus.head_on | bus.body_on), 0);
    probe(2, 30); checkOutput("midscan_tail_back", 32'(bus.body_on), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
